// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the write-back arbiter's state and queue-entry types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        NORMAL = 1'b0,
        STEAL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        word_t    wdat;
    } lu_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order queue of long-unit results with squash-by-register and a registered
// mask of registers still targeted by live entries.
module wb_result_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  regbits_t    push_wsel_i,
    input  word_t       push_wdat_i,
    input  logic        pop_i,
    input  logic        squash_i,
    input  regbits_t    squash_wsel_i,
    output logic        full_o,
    output logic        empty_o,
    output lu_entry_t   head_o,
    output logic [31:0] pend_mask_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    lu_entry_t   mem_q [DEPTH];
    lu_entry_t   mem_d [DEPTH];
    logic [31:0] pend_q, pend_d;

    assign empty_o     = (wptr_q == rptr_q);
    assign full_o      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o      = mem_q[rptr_q[AW-1:0]];
    assign pend_mask_o = pend_q;

    // Squash runs before the push so a same-cycle arrival survives; popped
    // slots are cleared so unoccupied slots never contribute to the mask.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].wsel == squash_wsel_i)) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
        if (pop_i && !empty_o) begin
            mem_d[rptr_q[AW-1:0]].valid = 1'b0;
            rptr_d = rptr_q + PTR_ONE;
        end
        if (push_i && !full_o) begin
            mem_d[wptr_q[AW-1:0]] = '{valid: 1'b1, wsel: push_wsel_i, wdat: push_wdat_i};
            wptr_d = wptr_q + PTR_ONE;
        end
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_d[i].valid) begin
                pend_d[mem_d[i].wsel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            pend_q <= pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and queued
// long-unit results; a starvation counter occasionally stalls write-back.
module wb_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        wb_valid,
    input  logic        wb_wen,
    input  regbits_t    wb_wsel,
    input  word_t       wb_wdat,
    output logic        wb_ack,
    output logic        pipe_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  regbits_t    lu_wsel,
    input  word_t       lu_wdat,
    output logic        rf_wen,
    output regbits_t    rf_wsel,
    output word_t       rf_wdat,
    output logic [31:0] pend_mask
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fifo_full, fifo_empty;
    lu_entry_t     head;
    logic          push, pop, squash, pipe_req;
    logic          rf_wen_c, wb_ack_c, pipe_stall_c;

    assign pipe_req = wb_valid & wb_wen & (wb_wsel != '0);
    assign lu_ready = nRST & ~fifo_full;
    assign push     = lu_valid & lu_ready & (lu_wsel != '0);

    assign rf_wen     = nRST & rf_wen_c;
    assign wb_ack     = nRST & wb_ack_c;
    assign pipe_stall = nRST & pipe_stall_c;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (CLK),
        .rst_n         (nRST),
        .push_i        (push),
        .push_wsel_i   (lu_wsel),
        .push_wdat_i   (lu_wdat),
        .pop_i         (pop),
        .squash_i      (squash),
        .squash_wsel_i (wb_wsel),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_o        (head),
        .pend_mask_o   (pend_mask)
    );

    // A squashed head still pops but writes nothing and leaves the counter alone.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_wen_c     = 1'b0;
        rf_wsel      = head.wsel;
        rf_wdat      = head.wdat;
        wb_ack_c     = 1'b0;
        pipe_stall_c = 1'b0;
        pop          = 1'b0;
        squash       = 1'b0;
        if (state_q == NORMAL) begin
            wb_ack_c = wb_valid;
            if (pipe_req) begin
                rf_wen_c = 1'b1;
                rf_wsel  = wb_wsel;
                rf_wdat  = wb_wdat;
                squash   = 1'b1;
                if (!fifo_empty && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (!fifo_empty) begin
                rf_wen_c = head.valid;
                pop      = 1'b1;
                if (head.valid) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = '0;
            end
            if (cnt_d == LIMIT) begin
                state_d = STEAL;
            end
        end else begin
            pipe_stall_c = 1'b1;
            cnt_d        = '0;
            state_d      = NORMAL;
            if (!fifo_empty) begin
                rf_wen_c = head.valid;
                pop      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter against a queue-based model
// of the port-sharing rules.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        wb_ack, pipe_stall;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_wsel;
    logic [31:0] lu_wdat;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [31:0] pend_mask;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .wb_valid   (wb_valid),
        .wb_wen     (wb_wen),
        .wb_wsel    (wb_wsel),
        .wb_wdat    (wb_wdat),
        .wb_ack     (wb_ack),
        .pipe_stall (pipe_stall),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_wsel    (lu_wsel),
        .lu_wdat    (lu_wdat),
        .rf_wen     (rf_wen),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .pend_mask  (pend_mask)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
        bit          live;
    } model_entry_t;

    typedef struct {
        bit          rfWen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        bit          ack;
        bit          stall;
        bit          ready;
        logic [31:0] pend;
        int          cyc;
    } expect_t;

    model_entry_t mq[$];
    expect_t      expQ[$];
    int           mCnt = 0;
    bit           mSteal = 0;
    bit           lastStall = 0;
    bit           luPending = 0;
    int           cycNum = 0;
    int           testsRun = 0;
    int           testsFailed = 0;

    // Drive one cycle of inputs and advance the reference model across the edge that ends it.
    task automatic applyStimulus(input logic rn, input logic wv, input logic ww, input logic [4:0] ws,
                                 input logic [31:0] wd, input logic lv, input logic [4:0] ls,
                                 input logic [31:0] ld);
        expect_t      e;
        model_entry_t h;
        bit           preq;
        @(posedge CLK);
        #1;
        nRST = rn; wb_valid = wv; wb_wen = ww; wb_wsel = ws; wb_wdat = wd;
        lu_valid = lv; lu_wsel = ls; lu_wdat = ld;
        e = '{rfWen: 0, wsel: 5'd0, wdat: 32'd0, ack: 0, stall: 0, ready: 0, pend: 32'd0, cyc: cycNum};
        if (!rn) begin
            mq.delete();
            mCnt = 0;
            mSteal = 0;
        end else begin
            e.ready = (mq.size() < DEPTH);
            foreach (mq[i]) if (mq[i].live) e.pend[mq[i].wsel] = 1'b1;
            if (mSteal) begin
                e.stall = 1;
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    e.rfWen = h.live; e.wsel = h.wsel; e.wdat = h.wdat;
                end
                mCnt = 0;
                mSteal = 0;
            end else begin
                e.ack = wv;
                preq = wv && ww && (ws != 5'd0);
                if (preq) begin
                    e.rfWen = 1; e.wsel = ws; e.wdat = wd;
                    foreach (mq[i]) if (mq[i].wsel == ws) mq[i].live = 0;
                    if (mq.size() > 0 && mCnt < STARVE_LIMIT) mCnt++;
                end else if (mq.size() > 0) begin
                    h = mq.pop_front();
                    e.rfWen = h.live; e.wsel = h.wsel; e.wdat = h.wdat;
                    if (h.live) mCnt = 0;
                end else begin
                    mCnt = 0;
                end
                mSteal = (mCnt == STARVE_LIMIT);
            end
            if (lv && e.ready && ls != 5'd0) mq.push_back('{wsel: ls, wdat: ld, live: 1});
        end
        lastStall = e.stall;
        luPending = lv && !e.ready;
        expQ.push_back(e);
        cycNum++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
    always @(negedge CLK) begin
        expect_t e;
        bit      ok;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            ok = (rf_wen === e.rfWen) && (!e.rfWen || (rf_wsel === e.wsel && rf_wdat === e.wdat))
                 && (wb_ack === e.ack) && (pipe_stall === e.stall) && (lu_ready === e.ready)
                 && (pend_mask === e.pend);
            testsRun++;
            if (!ok) begin
                testsFailed++;
                $display("[TB] FAIL cycle%0d: got wen=%b sel=%0d dat=%h ack=%b stall=%b rdy=%b pend=%h; want wen=%b sel=%0d dat=%h ack=%b stall=%b rdy=%b pend=%h",
                         e.cyc, rf_wen, rf_wsel, rf_wdat, wb_ack, pipe_stall, lu_ready, pend_mask,
                         e.rfWen, e.wsel, e.wdat, e.ack, e.stall, e.ready, e.pend);
            end
        end
    end

    initial begin
        logic        rn, wv, ww, lv;
        logic [4:0]  ws, ls;
        logic [31:0] wd, ld;
        nRST = 0; wb_valid = 0; wb_wen = 0; wb_wsel = 0; wb_wdat = 0;
        lu_valid = 0; lu_wsel = 0; lu_wdat = 0;

        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(1);

        // Idle pipeline: queued result reaches the port the following cycle.
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 1, 5'd8, 32'hDEADBEEF);
        idle(3);

        // Continuous pipeline writes starve one queued entry until a steal.
        applyStimulus(1, 1, 1, 5'd9, 32'h100, 1, 5'd3, 32'h33);
        for (int i = 1; i < 7; i++) applyStimulus(1, 1, 1, 5'd9, 32'h100 + i, 0, 5'd0, 32'd0);
        idle(2);

        // Fill the queue, hold a third result until a slot frees.
        applyStimulus(1, 1, 1, 5'd9, 32'h200, 1, 5'd10, 32'hA);
        applyStimulus(1, 1, 1, 5'd9, 32'h201, 1, 5'd11, 32'hB);
        applyStimulus(1, 1, 1, 5'd9, 32'h202, 1, 5'd12, 32'hC);
        applyStimulus(1, 0, 0, 5'd0, 32'd0,   1, 5'd12, 32'hC);
        applyStimulus(1, 0, 0, 5'd0, 32'd0,   1, 5'd12, 32'hC);
        idle(3);

        // Pipeline write to the same register squashes the queued result.
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1);
        applyStimulus(1, 1, 1, 5'd5, 32'h2, 0, 5'd0, 32'd0);
        idle(3);

        // Writes to $0 from either side complete without touching the register file.
        applyStimulus(1, 1, 1, 5'd0, 32'h77, 1, 5'd0, 32'h88);
        idle(2);

        // Reset in the middle of a starvation run with two entries queued.
        applyStimulus(1, 1, 1, 5'd9, 32'h300, 1, 5'd20, 32'h14);
        applyStimulus(1, 1, 1, 5'd9, 32'h301, 1, 5'd21, 32'h15);
        applyStimulus(1, 1, 1, 5'd9, 32'h302, 0, 5'd0,  32'd0);
        applyStimulus(0, 1, 1, 5'd9, 32'h303, 1, 5'd22, 32'h16);
        applyStimulus(0, 1, 1, 5'd9, 32'h303, 1, 5'd22, 32'h16);
        idle(3);

        wv = 0; ww = 0; ws = 0; wd = 0; lv = 0; ls = 0; ld = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!lastStall) begin
                wv = ($urandom_range(0, 3) != 0);
                ww = ($urandom_range(0, 4) != 0);
                ws = 5'($urandom_range(0, 7));
                wd = $urandom;
            end
            if (!luPending) begin
                lv = ($urandom_range(0, 2) == 0);
                ls = 5'($urandom_range(0, 7));
                ld = $urandom;
            end
            rn = ($urandom_range(0, 299) != 0);
            applyStimulus(rn, wv, ww, ws, wd, lv, ls, ld);
        end
        idle(4);

        @(negedge CLK);
        #1;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
